// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-axis porch/sync description, the standard
// 640x480@60 mode, and a helper that sums an axis into its total length.
package vga_pkg;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
   } vga_axis_t;

   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
   } vga_timing_t;

   localparam vga_timing_t VGA_640x480_60 = '{
      h: '{active: 640, fp: 16, sync: 96, bp: 48},
      v: '{active: 480, fp: 10, sync: 2,  bp: 33}
   };

   // Total length of one axis (pixels per line or lines per frame)
   function automatic int total(vga_axis_t a);
      return a.active + a.fp + a.sync + a.bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter advanced by a carry-in,
// with a carry-out on wrap and registered sync/active flags decoded from
// the next count so they line up with the count they describe.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter bit POL    = 1'b0,
   parameter int CW     = 10
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          inc_i,
   output logic [CW-1:0] count_o,
   output logic          carry_o,
   output logic          sync_o,
   output logic          active_o
);

   localparam int TOTAL      = total(vga_axis_t'{active: ACTIVE, fp: FP, sync: SYNC, bp: BP});
   localparam int SYNC_FIRST = ACTIVE + FP;
   localparam int SYNC_LAST  = ACTIVE + FP + SYNC - 1;

   logic [CW-1:0] count_q, count_d;
   logic          sync_q, sync_d;
   logic          active_q, active_d;
   logic          last;

   assign last     = (count_q == CW'(TOTAL - 1));
   assign carry_o  = inc_i && last;
   assign count_o  = count_q;
   assign sync_o   = sync_q;
   assign active_o = active_q;

   // Next position plus the flags that will describe that position
   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         count_d = last ? '0 : count_q + CW'(1);
      end
      active_d = (count_d < CW'(ACTIVE));
      sync_d   = ((count_d >= CW'(SYNC_FIRST)) && (count_d <= CW'(SYNC_LAST))) ? POL : ~POL;
   end

   // Position and decoded flags; reset parks at the first active pixel
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q  <= '0;
         sync_q   <= ~POL;
         active_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         sync_q   <= sync_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/DVI timing generator: pixel-clock prescaler, horizontal and vertical
// axis counters, line/frame start markers and a completed-frame counter.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = VGA_640x480_60.h.active,
   parameter int H_FP      = VGA_640x480_60.h.fp,
   parameter int H_SYNC    = VGA_640x480_60.h.sync,
   parameter int H_BP      = VGA_640x480_60.h.bp,
   parameter int V_ACTIVE  = VGA_640x480_60.v.active,
   parameter int V_FP      = VGA_640x480_60.v.fp,
   parameter int V_SYNC    = VGA_640x480_60.v.sync,
   parameter int V_BP      = VGA_640x480_60.v.bp,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 1,
   parameter int CW        = 10
) (
   input  logic          pixel_clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          pix_stb,
   output logic [CW-1:0] x_count,
   output logic [CW-1:0] y_count,
   output logic          hsync,
   output logic          vsync,
   output logic          display_on,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int H_TOTAL = total(vga_axis_t'{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP});
   localparam int V_TOTAL = total(vga_axis_t'{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP});
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be non-zero");
   end
   if (((H_TOTAL - 1) >= (1 << CW)) || ((V_TOTAL - 1) >= (1 << CW))) begin : g_bad_cw
      $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
   end

   logic [DW-1:0] div_q, div_d;
   logic          div_last;
   logic          h_carry, v_carry;
   logic          h_active, v_active;
   logic          line_start_q, frame_start_q;
   logic [7:0]    frame_cnt_q, frame_cnt_d;

   assign div_last    = (div_q == DW'(CLK_DIV - 1));
   assign pix_stb     = en && div_last;
   assign display_on  = h_active && v_active;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

   // Prescaler only moves while running, so a freeze resumes mid-pixel
   always_comb begin
      div_d = div_q;
      if (en) begin
         div_d = div_last ? '0 : div_q + DW'(1);
      end
      frame_cnt_d = frame_cnt_q + {7'd0, v_carry};
   end

   // Prescaler, markers and frame counter; markers track the wrap carries
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         div_q         <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
      end else begin
         div_q         <= div_d;
         line_start_q  <= h_carry;
         frame_start_q <= v_carry;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HSYNC_POL),
      .CW     (CW)
   ) u_h_axis (
      .clk_i    (pixel_clk),
      .rst_ni   (rst_n),
      .inc_i    (pix_stb),
      .count_o  (x_count),
      .carry_o  (h_carry),
      .sync_o   (hsync),
      .active_o (h_active)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VSYNC_POL),
      .CW     (CW)
   ) u_v_axis (
      .clk_i    (pixel_clk),
      .rst_ni   (rst_n),
      .inc_i    (h_carry),
      .count_o  (y_count),
      .carry_o  (v_carry),
      .sync_o   (vsync),
      .active_o (v_active)
   );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (tiny 8x4 positive-sync mode,
// small mode with a /2 prescaler, default 640x480) checked every cycle
// against a pixel-count model, plus a vector table and targeted sequences.
module tb_vga_timing_gen;

   typedef struct {
      int     ht, vt, ha, va, hs0, hs1, vs0, vs1, dv;
      bit     hp, vp;
      longint ec, px;
      bit     ls, fs;
   } model_t;

   typedef struct {
      bit rstN;
      bit en;
      int n;
      int x, y;
      bit hs, vs, de, stb, ls, fs;
      int fc;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA, enA, stbA, hsA, vsA, deA, lsA, fsA;
   logic [9:0] xA, yA;
   logic [7:0] fcA;
   logic       rstB, enB, stbB, hsB, vsB, deB, lsB, fsB;
   logic [9:0] xB, yB;
   logic [7:0] fcB;
   logic       rstC, enC, stbC, hsC, vsC, deC, lsC, fsC;
   logic [9:0] xC, yC;
   logic [7:0] fcC;

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   bit     bRandom = 1'b0;
   model_t mA, mB, mC;
   vec_t   tbl[12];

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CW(10)
   ) dutA (
      .pixel_clk(clk), .rst_n(rstA), .en(enA), .pix_stb(stbA),
      .x_count(xA), .y_count(yA), .hsync(hsA), .vsync(vsA),
      .display_on(deA), .line_start(lsA), .frame_start(fsA), .frame_cnt(fcA)
   );

   vga_timing_gen #(
      .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2), .CW(10)
   ) dutB (
      .pixel_clk(clk), .rst_n(rstB), .en(enB), .pix_stb(stbB),
      .x_count(xB), .y_count(yB), .hsync(hsB), .vsync(vsB),
      .display_on(deB), .line_start(lsB), .frame_start(fsB), .frame_cnt(fcB)
   );

   vga_timing_gen dutC (
      .pixel_clk(clk), .rst_n(rstC), .en(enC), .pix_stb(stbC),
      .x_count(xC), .y_count(yC), .hsync(hsC), .vsync(vsC),
      .display_on(deC), .line_start(lsC), .frame_start(fsC), .frame_cnt(fcC)
   );

   // Model state is just "enabled cycles seen" and "pixels emitted"
   function automatic model_t mkModel(input int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, dv,
                                      input bit hp, vp);
      model_t m;
      m.ha  = ha;
      m.va  = va;
      m.ht  = ha + hfp + hsy + hbp;
      m.vt  = va + vfp + vsy + vbp;
      m.hs0 = ha + hfp;
      m.hs1 = ha + hfp + hsy;
      m.vs0 = va + vfp;
      m.vs1 = va + vfp + vsy;
      m.dv  = dv;
      m.hp  = hp;
      m.vp  = vp;
      m.ec  = 0;
      m.px  = 0;
      m.ls  = 1'b0;
      m.fs  = 1'b0;
      return m;
   endfunction

   function automatic model_t mstep(input model_t mi, input bit rstN, input bit en);
      model_t m;
      bit     stb;
      m = mi;
      if (!rstN) begin
         m.ec = 0;
         m.px = 0;
         m.ls = 1'b0;
         m.fs = 1'b0;
      end else if (en) begin
         stb  = ((m.ec % m.dv) == m.dv - 1);
         m.ec = m.ec + 1;
         if (stb) begin
            m.px = m.px + 1;
            m.ls = ((m.px % m.ht) == 0);
            m.fs = ((m.px % (m.ht * m.vt)) == 0);
         end else begin
            m.ls = 1'b0;
            m.fs = 1'b0;
         end
      end else begin
         m.ls = 1'b0;
         m.fs = 1'b0;
      end
      return m;
   endfunction

   function automatic logic [33:0] mexp(input model_t m, input bit en);
      longint x, y, f;
      logic   hs, vs, de, stb;
      x   = m.px % m.ht;
      y   = (m.px / m.ht) % m.vt;
      f   = (m.px / (m.ht * m.vt)) % 256;
      hs  = (x >= m.hs0 && x < m.hs1) ? m.hp : ~m.hp;
      vs  = (y >= m.vs0 && y < m.vs1) ? m.vp : ~m.vp;
      de  = (x < m.ha) && (y < m.va);
      stb = en && ((m.ec % m.dv) == m.dv - 1);
      return {stb, 10'(x), 10'(y), hs, vs, de, m.ls, m.fs, 8'(f)};
   endfunction

   task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got stb=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d, want stb=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d",
                  name, cyc, act[33], act[32:23], act[22:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                  exp[33], exp[32:23], exp[22:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   // One clock per iteration: advance models, sample #1 after the edge, compare
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         mA = mstep(mA, rstA, enA);
         mB = mstep(mB, rstB, enB);
         mC = mstep(mC, rstC, enC);
         @(posedge clk);
         #1;
         cyc++;
         checkOutput("A model", {stbA, xA, yA, hsA, vsA, deA, lsA, fsA, fcA}, mexp(mA, enA));
         checkOutput("B model", {stbB, xB, yB, hsB, vsB, deB, lsB, fsB, fcB}, mexp(mB, enB));
         checkOutput("C model", {stbC, xC, yC, hsC, vsC, deC, lsC, fsC, fcC}, mexp(mC, enC));
         if (bRandom) begin
            rstB = ($urandom_range(0, 499) != 0);
            enB  = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   initial begin
      int  t0;
      bit  found;

      // rstN, en, n, x, y, hs, vs, de, stb, ls, fs, fc   (8x4 mode, active-high syncs)
      tbl[0]  = '{0, 1, 2,  0,  0, 0, 0, 1, 1, 0, 0, 0};
      tbl[1]  = '{1, 1, 9,  9,  0, 1, 0, 0, 1, 0, 0, 0};
      tbl[2]  = '{1, 1, 1,  10, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[3]  = '{1, 1, 1,  0,  1, 0, 0, 1, 1, 1, 0, 0};
      tbl[4]  = '{1, 1, 8,  8,  1, 0, 0, 0, 1, 0, 0, 0};
      tbl[5]  = '{1, 0, 5,  8,  1, 0, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{1, 1, 1,  9,  1, 1, 0, 0, 1, 0, 0, 0};
      tbl[7]  = '{1, 1, 35, 0,  5, 0, 1, 0, 1, 1, 0, 0};
      tbl[8]  = '{1, 1, 22, 0,  0, 0, 0, 1, 1, 1, 1, 1};
      tbl[9]  = '{1, 1, 30, 8,  2, 0, 0, 0, 1, 0, 0, 1};
      tbl[10] = '{0, 1, 1,  0,  0, 0, 0, 1, 1, 0, 0, 0};
      tbl[11] = '{1, 1, 1,  1,  0, 0, 0, 1, 1, 0, 0, 0};

      mA = mkModel(8, 1, 1, 1, 4, 1, 1, 1, 1, 1'b1, 1'b1);
      mB = mkModel(6, 2, 3, 1, 3, 1, 2, 1, 2, 1'b0, 1'b0);
      mC = mkModel(640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0);

      rstA = 1'b0; enA = 1'b1;
      rstB = 1'b0; enB = 1'b1;
      rstC = 1'b0; enC = 1'b1;
      applyStimulus(2);
      rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
      bRandom = 1'b1;

      // Default mode: hsync low exactly on x=656..751
      rstC = 1'b0;
      applyStimulus(1);
      rstC = 1'b1;
      applyStimulus(655);
      checkValue("C x before hsync", int'(xC), 655);
      checkValue("C hsync at 655", int'(hsC), 1);
      applyStimulus(1);
      checkValue("C hsync at 656", int'(hsC), 0);
      applyStimulus(95);
      checkValue("C hsync at 751", int'(hsC), 0);
      applyStimulus(1);
      checkValue("C hsync at 752", int'(hsC), 1);

      // Freeze at x=100,y=3 for 50 clocks, then resume at x=101
      applyStimulus(1748);
      checkValue("C x before freeze", int'(xC), 100);
      checkValue("C y before freeze", int'(yC), 3);
      enC = 1'b0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1);
         checkValue("C frozen x", int'(xC), 100);
         checkValue("C frozen y", int'(yC), 3);
         checkValue("C frozen hsync", int'(hsC), 1);
         checkValue("C frozen pix_stb", int'(stbC), 0);
      end
      enC = 1'b1;
      applyStimulus(1);
      checkValue("C x after resume", int'(xC), 101);

      // Tiny mode vector table, including freeze and mid-frame reset
      for (int i = 0; i < 12; i++) begin
         rstA = tbl[i].rstN;
         enA  = tbl[i].en;
         applyStimulus(tbl[i].n);
         checkOutput($sformatf("A vector %0d", i), {stbA, xA, yA, hsA, vsA, deA, lsA, fsA, fcA},
                     {tbl[i].stb, 10'(tbl[i].x), 10'(tbl[i].y), tbl[i].hs, tbl[i].vs, tbl[i].de,
                      tbl[i].ls, tbl[i].fs, 8'(tbl[i].fc)});
      end

      // Frame counter runs 0..255 and wraps back to 0
      rstA = 1'b0;
      applyStimulus(1);
      rstA = 1'b1;
      enA  = 1'b1;
      applyStimulus(255 * 77);
      checkValue("A frame_cnt at 255", int'(fcA), 255);
      checkValue("A frame_start at 255", int'(fsA), 1);
      checkValue("A x at frame 255", int'(xA), 0);
      applyStimulus(77);
      checkValue("A frame_cnt wrap", int'(fcA), 0);
      checkValue("A frame_start at wrap", int'(fsA), 1);

      // Prescaled mode: frame_start period is 12*7*2 clocks
      bRandom = 1'b0;
      rstB    = 1'b1;
      enB     = 1'b1;
      found   = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         applyStimulus(1);
         if (fsB) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL B first frame_start: no pulse within 400 cycles, want one");
      end
      t0    = cyc;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         applyStimulus(1);
         if (fsB) found = 1'b1;
      end
      checkValue("B frame period", found ? (cyc - t0) : -1, 168);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
